i2c_slave_ctrl: RTL and testbench

Protocol front end of the I2C EEPROM slave. It runs on the system clock and oversamples raw SCL/SDA. It detects START/STOP, receives and matches the device-address byte, and drives ACKs and read data onto SDA. It issues the addr_load / inc / byte strobes that the downstream address-pointer and counter stage consumes to select the memory row/column.

---
 rtl/i2c_slave_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_ctrl.sv
// ============================================================================
// Module   : i2c_slave_ctrl
// Brief    : I2C EEPROM slave protocol front end (START/STOP, address match,
//            ACK and read-data drive, pointer strobes). Oversamples SCL/SDA.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_slave_ctrl #(
    parameter logic [6:0] DEV_ADDR = 7'b1010000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       addr_load,
    output logic       rx_valid,
    output logic       inc,
    output logic       rw,
    input  logic [7:0] tx_data,
    output logic       busy
);

    localparam logic [3:0] c_st_idle     = 4'd0;
    localparam logic [3:0] c_st_devaddr  = 4'd1;
    localparam logic [3:0] c_st_devack   = 4'd2;
    localparam logic [3:0] c_st_waddr    = 4'd3;
    localparam logic [3:0] c_st_waddrack = 4'd4;
    localparam logic [3:0] c_st_wdata    = 4'd5;
    localparam logic [3:0] c_st_wdataack = 4'd6;
    localparam logic [3:0] c_st_rdata    = 4'd7;
    localparam logic [3:0] c_st_rdack    = 4'd8;

    logic       r_scl_s1, r_scl_s2, r_scl_d;
    logic       r_sda_s1, r_sda_s2, r_sda_d;
    logic [3:0] r_state;
    logic [2:0] r_cnt;
    logic [7:0] r_shift;
    logic       r_ack_seen;
    logic       r_mack;

    logic       w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
    logic       w_start, w_stop, w_last_bit, w_match;
    logic [7:0] w_byte;

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_sda_rise = r_sda_s2 & ~r_sda_d;
    assign w_sda_fall = ~r_sda_s2 & r_sda_d;
    assign w_start    = w_sda_fall & r_scl_s2;
    assign w_stop     = w_sda_rise & r_scl_s2;
    assign w_byte     = {r_shift[6:0], r_sda_s2};
    assign w_last_bit = (r_cnt == 3'd7);
    assign w_match    = (w_byte[7:1] == DEV_ADDR);

    // Synchronizers reset to the idle-bus level so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl_in;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_in;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_cnt      <= 3'd0;
            r_shift    <= 8'h00;
            r_ack_seen <= 1'b0;
            r_mack     <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= 8'h00;
            addr_load  <= 1'b0;
            rx_valid   <= 1'b0;
            inc        <= 1'b0;
            rw         <= 1'b0;
            busy       <= 1'b0;
        end else begin
            addr_load <= 1'b0;
            rx_valid  <= 1'b0;
            inc       <= 1'b0;
            if (w_start) begin
                r_state    <= c_st_devaddr;
                r_cnt      <= 3'd0;
                r_ack_seen <= 1'b0;
                sda_oe     <= 1'b0;
                busy       <= 1'b1;
            end else if (w_stop) begin
                r_state    <= c_st_idle;
                r_cnt      <= 3'd0;
                r_ack_seen <= 1'b0;
                sda_oe     <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (r_state)
                    c_st_devaddr: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            r_cnt   <= r_cnt + 3'd1;
                            if (w_last_bit) begin
                                if (w_match) begin
                                    rw         <= w_byte[0];
                                    r_ack_seen <= 1'b0;
                                    r_state    <= c_st_devack;
                                end else begin
                                    r_state <= c_st_idle;
                                end
                            end
                        end
                    end
                    c_st_waddr, c_st_wdata: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            r_cnt   <= r_cnt + 3'd1;
                            if (w_last_bit) begin
                                rx_data    <= w_byte;
                                r_ack_seen <= 1'b0;
                                if (r_state == c_st_waddr) begin
                                    addr_load <= 1'b1;
                                    r_state   <= c_st_waddrack;
                                end else begin
                                    rx_valid <= 1'b1;
                                    r_state  <= c_st_wdataack;
                                end
                            end
                        end
                    end
                    // First SCL fall starts the ACK; the fall after the 9th rise ends it.
                    c_st_devack, c_st_waddrack, c_st_wdataack: begin
                        if (w_scl_rise) begin
                            r_ack_seen <= 1'b1;
                        end else if (w_scl_fall) begin
                            if (!r_ack_seen) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe     <= 1'b0;
                                r_ack_seen <= 1'b0;
                                r_cnt      <= 3'd0;
                                if (r_state == c_st_devack) begin
                                    if (rw) begin
                                        r_state <= c_st_rdata;
                                        r_shift <= tx_data;
                                        sda_oe  <= ~tx_data[7];
                                    end else begin
                                        r_state <= c_st_waddr;
                                    end
                                end else begin
                                    r_state <= c_st_wdata;
                                    if (r_state == c_st_wdataack) begin
                                        inc <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    c_st_rdata: begin
                        if (w_scl_rise) begin
                            r_cnt <= r_cnt + 3'd1;
                            if (w_last_bit) begin
                                r_ack_seen <= 1'b0;
                                r_state    <= c_st_rdack;
                            end
                        end else if (w_scl_fall && (r_cnt != 3'd0)) begin
                            r_shift <= {r_shift[6:0], 1'b0};
                            sda_oe  <= ~r_shift[6];
                        end
                    end
                    c_st_rdack: begin
                        if (w_scl_rise) begin
                            r_ack_seen <= 1'b1;
                            r_mack     <= ~r_sda_s2;
                        end else if (w_scl_fall) begin
                            if (!r_ack_seen) begin
                                sda_oe <= 1'b0;
                            end else begin
                                r_ack_seen <= 1'b0;
                                r_cnt      <= 3'd0;
                                if (r_mack) begin
                                    inc     <= 1'b1;
                                    r_shift <= tx_data;
                                    sda_oe  <= ~tx_data[7];
                                    r_state <= c_st_rdata;
                                end else begin
                                    sda_oe  <= 1'b0;
                                    r_state <= c_st_idle;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_ctrl.sv
// ============================================================================
// Module   : tb_i2c_slave_ctrl
// Brief    : Bus-level bench for i2c_slave_ctrl: table of write transfers,
//            random transfers against a transaction model, corner sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_i2c_slave_ctrl;

    localparam logic [6:0] C_DEV = 7'b1010000;

    typedef struct {
        logic [7:0] dev;
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic       exp_ack;
        int         exp_al;
        int         exp_rv;
        int         exp_inc;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic [7:0] tx_data;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       addr_load;
    logic       rx_valid;
    logic       inc;
    logic       rw;
    logic       busy;

    int checks = 0;
    int failures = 0;
    logic [7:0] al_log[$];
    logic [7:0] rv_log[$];
    int inc_cnt = 0;
    int overlap_cnt = 0;

    always #5 clk = ~clk;

    // Open-drain bus: either side can pull low.
    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_ctrl #(.DEV_ADDR(C_DEV)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_m),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .rx_data   (rx_data),
        .addr_load (addr_load),
        .rx_valid  (rx_valid),
        .inc       (inc),
        .rw        (rw),
        .tx_data   (tx_data),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (addr_load) al_log.push_back(rx_data);
            if (rx_valid) rv_log.push_back(rx_data);
            if (inc) inc_cnt++;
            if ((addr_load & rx_valid) | (addr_load & inc) | (rx_valid & inc)) overlap_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic obs);
        wait_clks(2);
        sda_m = b;
        wait_clks(8);
        scl_m = 1'b1;
        wait_clks(5);
        obs = sda_bus;
        wait_clks(5);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        wait_clks(2);
        sda_m = 1'b1;
        wait_clks(8);
        scl_m = 1'b1;
        wait_clks(10);
        sda_m = 1'b0;
        wait_clks(10);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clks(2);
        sda_m = 1'b0;
        wait_clks(8);
        scl_m = 1'b1;
        wait_clks(10);
        sda_m = 1'b1;
        wait_clks(10);
    endtask

    task automatic scl_low();
        wait_clks(2);
        scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic o;
        for (int i = 7; i >= 0; i--) send_bit(b[i], o);
        send_bit(1'b1, o);
        ack = ~o;
    endtask

    task automatic read_byte(input logic mack, input logic [7:0] next_tx,
                             output logic [7:0] d, output logic ack_line);
        logic o;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, o);
            d = {d[6:0], o};
        end
        tx_data = next_tx;
        send_bit(~mack, o);
        ack_line = o;
    endtask

    // Transaction-level expectation for a write-style transfer.
    function automatic vec_t model_write(input logic [7:0] dev, input int n,
                                         input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2);
        vec_t v;
        logic m;
        m = (dev[7:1] == C_DEV);
        v.dev = dev; v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2;
        v.exp_ack = m;
        v.exp_al  = (m && n > 0) ? 1 : 0;
        v.exp_rv  = (m && n > 1) ? n - 1 : 0;
        v.exp_inc = v.exp_rv;
        return v;
    endfunction

    task automatic apply_write(input vec_t v);
        int al0, rv0, inc0;
        logic a;
        logic [7:0] bv [3];
        bv = '{v.b0, v.b1, v.b2};
        al0 = al_log.size(); rv0 = rv_log.size(); inc0 = inc_cnt;
        i2c_start();
        check("wr_busy_after_start", busy, 1);
        write_byte(v.dev, a);
        check("wr_dev_ack", a, v.exp_ack);
        for (int i = 0; i < v.n; i++) begin
            write_byte(bv[i], a);
            check("wr_byte_ack", a, v.exp_ack);
        end
        i2c_stop();
        check("wr_busy_after_stop", busy, 0);
        check("wr_addr_load_count", al_log.size() - al0, v.exp_al);
        check("wr_rx_valid_count", rv_log.size() - rv0, v.exp_rv);
        check("wr_inc_count", inc_cnt - inc0, v.exp_inc);
        if (v.exp_al > 0) check("wr_addr_value", al_log[al0], bv[0]);
        for (int k = 0; k < v.exp_rv; k++) check("wr_data_value", rv_log[rv0 + k], bv[k + 1]);
    endtask

    task automatic do_read(input logic [7:0] dev, input int n, input logic [7:0] t0,
                           input logic [7:0] t1, input logic [7:0] t2, input logic [7:0] t3);
        int al0, rv0, inc0;
        logic a, line;
        logic [7:0] d;
        logic [7:0] tq [4];
        tq = '{t0, t1, t2, t3};
        al0 = al_log.size(); rv0 = rv_log.size(); inc0 = inc_cnt;
        tx_data = tq[0];
        i2c_start();
        write_byte(dev, a);
        check("rd_dev_ack", a, 1);
        check("rd_rw", rw, 1);
        for (int i = 0; i < n; i++) begin
            read_byte(i < n - 1, (i < 3) ? tq[i + 1] : 8'h00, d, line);
            check("rd_data", d, tq[i]);
            if (i == n - 1) check("rd_nack_released", line, 1);
        end
        i2c_stop();
        check("rd_inc_count", inc_cnt - inc0, n - 1);
        check("rd_no_addr_load", al_log.size() - al0, 0);
        check("rd_no_rx_valid", rv_log.size() - rv0, 0);
        check("rd_sda_released", sda_oe, 0);
        check("rd_busy_after_stop", busy, 0);
    endtask

    initial begin
        vec_t tbl [6];
        vec_t v;
        int al0, rv0, inc0, t, n;
        logic a, o, line, match, rd;
        logic [7:0] d, dev, c;
        logic [3:0] pb;

        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
        wait_clks(5);
        reset = 1'b0;
        wait_clks(5);
        check("reset_outputs", {sda_oe, rx_data, addr_load, rx_valid, inc, rw, busy}, 0);

        tbl[0] = '{8'hA0, 2, 8'h12, 8'h34, 8'h00, 1'b1, 1, 1, 1};
        tbl[1] = '{8'hA0, 3, 8'h12, 8'h34, 8'h56, 1'b1, 1, 2, 2};
        tbl[2] = '{8'hA0, 1, 8'h7F, 8'h00, 8'h00, 1'b1, 1, 0, 0};
        tbl[3] = '{8'hA2, 2, 8'h55, 8'hAA, 8'h00, 1'b0, 0, 0, 0};
        tbl[4] = '{8'h20, 1, 8'hA0, 8'h00, 8'h00, 1'b0, 0, 0, 0};
        tbl[5] = '{8'hA0, 0, 8'h00, 8'h00, 8'h00, 1'b1, 0, 0, 0};
        for (int i = 0; i < 6; i++) apply_write(tbl[i]);

        // Read with master ACK then NACK: 0x5A then 0xC3.
        do_read(8'hA1, 2, 8'h5A, 8'hC3, 8'h00, 8'h00);

        // Repeated START after the word address, then read.
        al0 = al_log.size(); rv0 = rv_log.size();
        i2c_start();
        write_byte(8'hA0, a);
        write_byte(8'h40, a);
        tx_data = 8'h3C;
        i2c_start();
        check("rs_busy", busy, 1);
        write_byte(8'hA1, a);
        check("rs_dev_ack", a, 1);
        check("rs_rw", rw, 1);
        read_byte(1'b0, 8'h00, d, line);
        check("rs_read_data", d, 8'h3C);
        i2c_stop();
        check("rs_addr_load_count", al_log.size() - al0, 1);
        check("rs_addr_value", al_log[al0], 8'h40);
        check("rs_no_rx_valid", rv_log.size() - rv0, 0);

        // STOP after 4 bits of a data byte, then an un-STARTed byte is ignored.
        rv0 = rv_log.size(); inc0 = inc_cnt;
        i2c_start();
        write_byte(8'hA0, a);
        write_byte(8'h10, a);
        pb = 4'b1011;
        for (int i = 3; i >= 0; i--) send_bit(pb[i], o);
        i2c_stop();
        check("pstop_busy", busy, 0);
        scl_low();
        write_byte(8'hA0, a);
        check("pstop_idle_no_ack", a, 0);
        i2c_stop();
        check("pstop_no_rx_valid", rv_log.size() - rv0, 0);
        check("pstop_no_inc", inc_cnt - inc0, 0);

        // Reset while the slave drives the device-address ACK.
        i2c_start();
        c = 8'hA1;
        for (int i = 7; i >= 0; i--) send_bit(c[i], o);
        t = 0;
        while (!sda_oe && t < 40) begin
            wait_clks(1);
            t++;
        end
        check("rst_ack_driven", sda_oe, 1);
        check("rst_rw_before", rw, 1);
        reset = 1'b1;
        wait_clks(1);
        check("rst_sda_released", sda_oe, 0);
        check("rst_all_outputs", {sda_oe, rx_data, addr_load, rx_valid, inc, rw, busy}, 0);
        reset = 1'b0;
        wait_clks(2);
        i2c_stop();
        check("rst_busy_idle", busy, 0);
        apply_write(tbl[0]);

        // Random transfers against the transaction model.
        for (int it = 0; it < 10; it++) begin
            match = ($urandom_range(0, 3) != 0);
            rd = 1'($urandom_range(0, 1));
            if (match) begin
                dev = {C_DEV, rd};
            end else begin
                dev = 8'($urandom);
                while (dev[7:1] == C_DEV) dev = 8'($urandom);
            end
            if (match && rd) begin
                n = $urandom_range(1, 3);
                do_read(dev, n, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            end else begin
                n = $urandom_range(0, 3);
                v = model_write(dev, n, 8'($urandom), 8'($urandom), 8'($urandom));
                apply_write(v);
            end
        end

        check("strobe_overlap", overlap_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
